// File: rtl/gelu_lut.sv
// GELU lookup for signed Q3.4 operands with a single registered output stage.
// Define GELU_LUT_HALF_TABLE_EN to store only x <= 0 and derive x > 0 via GELU(x) = x + GELU(-x).
module gelu_lut (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [7:0] x_in,
  output logic signed [7:0] y_out
);

  // Magnitude of round(16*GELU(-k/16)) for k = 0..128.
  function automatic logic [7:0] neg_mag(input int unsigned k);
    if (k >= 36)      return 8'd0;
    else if (k >= 25) return 8'd1;
    else if (k >= 17) return 8'd2;
    else if (k >= 9)  return 8'd3;
    else if (k >= 4)  return 8'd2;
    else if (k >= 2)  return 8'd1;
    else              return 8'd0;
  endfunction

  logic [7:0] lut_y;

`ifdef GELU_LUT_HALF_TABLE_EN
  function automatic logic [128:0][7:0] build_half();
    logic [128:0][7:0] t;
    for (int unsigned k = 0; k <= 128; k++) begin
      t[k] = 8'd0 - neg_mag(k);
    end
    return t;
  endfunction

  localparam logic [128:0][7:0] HALF = build_half();

  logic [7:0] idx;

  // -(-128) wraps to 8'h80, which is exactly index 128 when read unsigned.
  always_comb begin
    idx   = x_in[7] ? 8'(-x_in) : 8'(x_in);
    lut_y = x_in[7] ? HALF[idx] : 8'(x_in) + HALF[idx];
  end
`else
  function automatic logic [255:0][7:0] build_full();
    logic [255:0][7:0] t;
    for (int unsigned i = 0; i < 256; i++) begin
      if (i < 128) t[i] = 8'(i) - neg_mag(i);
      else         t[i] = 8'd0 - neg_mag(256 - i);
    end
    return t;
  endfunction

  localparam logic [255:0][7:0] FULL = build_full();

  always_comb begin
    lut_y = FULL[8'(x_in)];
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) y_out <= '0;
    else        y_out <= lut_y;
  end

endmodule

// File: tb/tb_gelu_lut.sv
// Directed bench for gelu_lut: reset behaviour, anchor points, full sweep against
// a hand-tabulated golden model, monotonicity/symmetry and a mid-stream reset.
module tb_gelu_lut;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] x_in;
  logic signed [7:0] y_out;

  int checks = 0;
  int errors = 0;

  // round(k * Q(k/16)) for k = 0..35, hand-evaluated; zero beyond k = 35.
  int mag_tab [0:35] = '{0, 0, 1, 1, 2, 2, 2, 2, 2,
                         3, 3, 3, 3, 3, 3, 3, 3,
                         2, 2, 2, 2, 2, 2, 2, 2,
                         1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

  logic signed [7:0] ys [0:255];

  int dx [10] = '{0, 8, 16, 32, -16, -32, -12, 127, -128, -64};
  int dy [10] = '{0, 6, 13, 31,  -3,  -1,  -3, 127,    0,   0};

  always #5 clk = ~clk;

  gelu_lut dut (
    .clk   (clk),
    .reset (reset),
    .x_in  (x_in),
    .y_out (y_out)
  );

  function automatic int golden(input int x);
    int k;
    int m;
    k = (x < 0) ? -x : x;
    m = (k <= 35) ? mag_tab[k] : 0;
    return (x < 0) ? -m : x - m;
  endfunction

  task automatic check(input string tag, input logic signed [7:0] obs,
                       input logic signed [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int x);
    @(negedge clk);
    x_in = 8'(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    x_in  = 8'sd16;
    #1 check("reset_async", y_out, 8'sd0);
    repeat (3) begin
      @(posedge clk);
      #1 check("reset_hold", y_out, 8'sd0);
    end
    @(negedge clk);
    check("reset_hold_neg", y_out, 8'sd0);
    reset = 1'b1;
    @(posedge clk);
    #1 check("first_after_release", y_out, 8'sd13);

    for (int i = 0; i < 10; i++) begin
      step(dx[i]);
      check($sformatf("point_%0d", dx[i]), y_out, 8'(dy[i]));
    end

    for (int x = -128; x <= 127; x++) begin
      step(x);
      check($sformatf("sweep_%0d", x), y_out, 8'(golden(x)));
      ys[x + 128] = y_out;
      #3 check($sformatf("hold_%0d", x), y_out, 8'(golden(x)));
    end

    for (int x = -12; x <= 126; x++) begin
      check($sformatf("mono_%0d", x), {7'd0, (ys[x + 129] >= ys[x + 128])}, 8'sd1);
    end
    for (int x = 1; x <= 127; x++) begin
      check($sformatf("sym_%0d", x), 8'(ys[x + 128] - ys[128 - x]), 8'(x));
    end

    step(40);
    check("pre_reset_40", y_out, 8'sd40);
    @(negedge clk);
    x_in = 8'sd41;
    #2 reset = 1'b0;
    #1 check("mid_reset_async", y_out, 8'sd0);
    @(posedge clk);
    #1 check("mid_reset_edge", y_out, 8'sd0);
    #1 reset = 1'b1;
    #1 check("mid_reset_released", y_out, 8'sd0);
    @(posedge clk);
    #1 check("after_mid_reset", y_out, 8'(golden(41)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
